// File: rtl/mem_arb.sv
// mem_arb: shares one halfword memory port between fetch (IF) and load/store (LS).
// LS has priority; a streak counter forces an IF grant to prevent starvation.
module mem_arb #(
  parameter int MEM_DEPTH     = 4096,
  parameter int LS_STREAK_MAX = 4,
  localparam int ADDR_WIDTH   = $clog2(MEM_DEPTH * 2),
  localparam int SW           = $clog2(LS_STREAK_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  input  logic [1:0]            i_if_mode,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  input  logic                  i_ls_req,
  input  logic [ADDR_WIDTH-1:0] i_ls_addr,
  input  logic [31:0]           i_ls_wdata,
  input  logic [1:0]            i_ls_rd_mode,
  input  logic [1:0]            i_ls_wr_mode,
  output logic                  o_ls_gnt,
  output logic                  o_ls_rvalid,
  output logic [31:0]           o_rdata,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_mc_addr,
  output logic [31:0]           o_mc_data,
  output logic [1:0]            o_mc_rd_mode,
  output logic [1:0]            o_mc_wr_mode,
  input  logic [31:0]           i_mc_data
);

  typedef enum logic {
    IDLE   = 1'b0,
    HOLD32 = 1'b1
  } state_e;

  localparam logic [SW-1:0] STREAK_MAX = SW'(LS_STREAK_MAX);

  state_e          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  // s1 completes next cycle, s2 the cycle after; own=1 means LS
  logic            s1_vld_q, s1_vld_d;
  logic            s1_own_q, s1_own_d;
  logic            s2_vld_q, s2_vld_d;
  logic            s2_own_q, s2_own_d;

  logic            ls_win, if_win;
  logic            ls_gnt, if_gnt;
  logic [1:0]      rd_m, wr_m;

  // Winner select, bus drive, response pipeline and streak update
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    err_d    = err_q;
    addr_d   = addr_q;
    data_d   = data_q;
    s1_vld_d = s2_vld_q;
    s1_own_d = s2_own_q;
    s2_vld_d = 1'b0;
    s2_own_d = 1'b0;
    ls_gnt   = 1'b0;
    if_gnt   = 1'b0;
    rd_m     = 2'd0;
    wr_m     = 2'd0;
    ls_win   = i_ls_req &&
               !(streak_q == STREAK_MAX && i_if_req);
    if_win   = i_if_req && !ls_win;

    if (state_q == HOLD32) begin
      state_d = IDLE;
    end else begin
      unique case (1'b1)
        ls_win: begin
          ls_gnt = 1'b1;
          addr_d = i_ls_addr;
          data_d = i_ls_wdata;
          wr_m   = i_ls_wr_mode;
          rd_m   = (i_ls_wr_mode != 2'd0) ? 2'd0
                                          : i_ls_rd_mode;
          if (i_ls_wr_mode != 2'd0 &&
              i_ls_rd_mode != 2'd0)
            err_d = 1'b1;
        end
        if_win: begin
          if_gnt = 1'b1;
          addr_d = i_if_addr;
          if (i_if_mode == 2'd1 || i_if_mode == 2'd2)
            rd_m = i_if_mode;
          else
            err_d = 1'b1;
        end
        default: ;
      endcase

      if (rd_m == 2'd2 || wr_m == 2'd2)
        state_d = HOLD32;

      if (rd_m == 2'd2) begin
        s2_vld_d = 1'b1;
        s2_own_d = ls_gnt;
      end else if (rd_m != 2'd0) begin
        s1_vld_d = 1'b1;
        s1_own_d = ls_gnt;
      end
    end

    if (!i_if_req || if_gnt)
      streak_d = '0;
    else if (ls_gnt && streak_q != STREAK_MAX)
      streak_d = streak_q + SW'(1);
  end

  // State, streak, sticky error, held bus values and response pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      s1_vld_q <= 1'b0;
      s1_own_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_own_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      s1_vld_q <= s1_vld_d;
      s1_own_q <= s1_own_d;
      s2_vld_q <= s2_vld_d;
      s2_own_q <= s2_own_d;
    end
  end

  // Outputs, forced to their reset values while rst is high
  always_comb begin
    o_if_gnt     = !rst && if_gnt;
    o_ls_gnt     = !rst && ls_gnt;
    o_if_rvalid  = !rst && s1_vld_q && !s1_own_q;
    o_ls_rvalid  = !rst && s1_vld_q && s1_own_q;
    o_rdata      = rst ? 32'd0 : i_mc_data;
    o_err        = !rst && err_q;
    o_mc_addr    = rst ? '0 : addr_d;
    o_mc_data    = rst ? 32'd0 : data_d;
    o_mc_rd_mode = rst ? 2'd0 : rd_m;
    o_mc_wr_mode = rst ? 2'd0 : wr_m;
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed checks of mem_arb arbitration, latency and errors.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_if_req;
  logic [12:0] i_if_addr;
  logic [1:0]  i_if_mode;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic        i_ls_req;
  logic [12:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [1:0]  i_ls_rd_mode;
  logic [1:0]  i_ls_wr_mode;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_rdata;
  logic        o_err;
  logic [12:0] o_mc_addr;
  logic [31:0] o_mc_data;
  logic [1:0]  o_mc_rd_mode;
  logic [1:0]  o_mc_wr_mode;
  logic [31:0] i_mc_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arb dut (
    .clk          (clk),
    .rst          (rst),
    .i_if_req     (i_if_req),
    .i_if_addr    (i_if_addr),
    .i_if_mode    (i_if_mode),
    .o_if_gnt     (o_if_gnt),
    .o_if_rvalid  (o_if_rvalid),
    .i_ls_req     (i_ls_req),
    .i_ls_addr    (i_ls_addr),
    .i_ls_wdata   (i_ls_wdata),
    .i_ls_rd_mode (i_ls_rd_mode),
    .i_ls_wr_mode (i_ls_wr_mode),
    .o_ls_gnt     (o_ls_gnt),
    .o_ls_rvalid  (o_ls_rvalid),
    .o_rdata      (o_rdata),
    .o_err        (o_err),
    .o_mc_addr    (o_mc_addr),
    .o_mc_data    (o_mc_data),
    .o_mc_rd_mode (o_mc_rd_mode),
    .o_mc_wr_mode (o_mc_wr_mode),
    .i_mc_data    (i_mc_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_if_req     = 1'b0;
    i_if_addr    = '0;
    i_if_mode    = 2'd0;
    i_ls_req     = 1'b0;
    i_ls_addr    = '0;
    i_ls_wdata   = '0;
    i_ls_rd_mode = 2'd0;
    i_ls_wr_mode = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    i_mc_data = 32'h1111_2222;
    i_ls_req = 1'b1;
    i_ls_rd_mode = 2'd2;
    i_ls_addr = 13'h0044;
    step();
    step();
    @(negedge clk);
    total++;
    if ({o_if_gnt, o_ls_gnt, o_if_rvalid, o_ls_rvalid,
         o_err, o_mc_rd_mode, o_mc_wr_mode} !== 7'd0) begin
      bad++;
      $display("FAIL reset_ctl got=%b%b%b%b%b %0d %0d want all 0",
               o_if_gnt, o_ls_gnt, o_if_rvalid, o_ls_rvalid,
               o_err, o_mc_rd_mode, o_mc_wr_mode);
    end
    total++;
    if (o_mc_addr !== 13'd0 || o_mc_data !== 32'd0) begin
      bad++;
      $display("FAIL reset_bus addr=%h data=%h want 0 0",
               o_mc_addr, o_mc_data);
    end
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++;
    if (o_ls_gnt !== 1'b0 || o_mc_rd_mode !== 2'd0 ||
        o_mc_addr !== 13'd0) begin
      bad++;
      $display("FAIL reset_idle gnt=%b rd=%0d addr=%h want 0 0 0",
               o_ls_gnt, o_mc_rd_mode, o_mc_addr);
    end
  endtask

  task automatic test_ls_load16();
    step();
    i_ls_req = 1'b1;
    i_ls_addr = 13'h0010;
    i_ls_rd_mode = 2'd1;
    @(negedge clk);
    total++;
    if (o_ls_gnt !== 1'b1 || o_mc_rd_mode !== 2'd1 ||
        o_mc_wr_mode !== 2'd0 || o_mc_addr !== 13'h0010 ||
        o_ls_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL ld16_issue gnt=%b rd=%0d wr=%0d addr=%h rv=%b want 1 1 0 0010 0",
               o_ls_gnt, o_mc_rd_mode, o_mc_wr_mode, o_mc_addr, o_ls_rvalid);
    end
    step();
    idle_inputs();
    i_mc_data = 32'h0000_BEEF;
    @(negedge clk);
    total++;
    if (o_ls_rvalid !== 1'b1 || o_if_rvalid !== 1'b0 ||
        o_rdata !== 32'h0000_BEEF) begin
      bad++;
      $display("FAIL ld16_resp lsrv=%b ifrv=%b rdata=%h want 1 0 0000beef",
               o_ls_rvalid, o_if_rvalid, o_rdata);
    end
    total++;
    if (o_ls_gnt !== 1'b0 || o_mc_rd_mode !== 2'd0 ||
        o_mc_addr !== 13'h0010) begin
      bad++;
      $display("FAIL ld16_hold gnt=%b rd=%0d addr=%h want 0 0 0010",
               o_ls_gnt, o_mc_rd_mode, o_mc_addr);
    end
    step();
    @(negedge clk);
    total++;
    if (o_ls_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL ld16_once lsrv=%b want 0", o_ls_rvalid);
    end
  endtask

  task automatic test_if32();
    step();
    i_if_req = 1'b1;
    i_if_addr = 13'h0100;
    i_if_mode = 2'd2;
    @(negedge clk);
    total++;
    if (o_if_gnt !== 1'b1 || o_mc_rd_mode !== 2'd2 ||
        o_mc_addr !== 13'h0100) begin
      bad++;
      $display("FAIL if32_issue gnt=%b rd=%0d addr=%h want 1 2 0100",
               o_if_gnt, o_mc_rd_mode, o_mc_addr);
    end
    step();
    idle_inputs();
    i_ls_req = 1'b1;
    i_ls_addr = 13'h0020;
    i_ls_rd_mode = 2'd1;
    @(negedge clk);
    total++;
    if (o_ls_gnt !== 1'b0 || o_mc_rd_mode !== 2'd0 ||
        o_mc_wr_mode !== 2'd0 || o_if_rvalid !== 1'b0 ||
        o_mc_addr !== 13'h0100) begin
      bad++;
      $display("FAIL if32_hold gnt=%b rd=%0d wr=%0d ifrv=%b addr=%h want 0 0 0 0 0100",
               o_ls_gnt, o_mc_rd_mode, o_mc_wr_mode, o_if_rvalid, o_mc_addr);
    end
    step();
    i_mc_data = 32'hCAFE_F00D;
    @(negedge clk);
    total++;
    if (o_ls_gnt !== 1'b1 || o_if_rvalid !== 1'b1 ||
        o_ls_rvalid !== 1'b0 || o_rdata !== 32'hCAFE_F00D) begin
      bad++;
      $display("FAIL if32_resp lsgnt=%b ifrv=%b lsrv=%b rdata=%h want 1 1 0 cafef00d",
               o_ls_gnt, o_if_rvalid, o_ls_rvalid, o_rdata);
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if (o_if_rvalid !== 1'b0 || o_ls_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL if32_after ifrv=%b lsrv=%b want 0 1",
               o_if_rvalid, o_ls_rvalid);
    end
  endtask

  task automatic test_streak();
    logic [9:0] exp_if;
    logic       prev_if;
    exp_if = 10'b1000010000;
    prev_if = 1'b0;
    step();
    i_if_req = 1'b1;
    i_if_addr = 13'h0080;
    i_if_mode = 2'd1;
    i_ls_req = 1'b1;
    i_ls_addr = 13'h0040;
    i_ls_rd_mode = 2'd1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (o_if_gnt !== exp_if[c] || o_ls_gnt !== !exp_if[c]) begin
        bad++;
        $display("FAIL streak_c%0d ifgnt=%b lsgnt=%b want %b %b",
                 c, o_if_gnt, o_ls_gnt, exp_if[c], !exp_if[c]);
      end
      total++;
      if (o_if_rvalid !== prev_if || o_ls_rvalid !== (c != 0 && !prev_if)) begin
        bad++;
        $display("FAIL streak_rv%0d ifrv=%b lsrv=%b want %b %b",
                 c, o_if_rvalid, o_ls_rvalid, prev_if, c != 0 && !prev_if);
      end
      prev_if = exp_if[c];
      step();
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    step();
    i_ls_req = 1'b1;
    i_ls_addr = 13'h0030;
    i_ls_rd_mode = 2'd3;
    @(negedge clk);
    total++;
    if (o_ls_gnt !== 1'b1 || o_mc_rd_mode !== 2'd3) begin
      bad++;
      $display("FAIL b2b_ls gnt=%b rd=%0d want 1 3", o_ls_gnt, o_mc_rd_mode);
    end
    step();
    idle_inputs();
    i_if_req = 1'b1;
    i_if_addr = 13'h0200;
    i_if_mode = 2'd1;
    @(negedge clk);
    total++;
    if (o_if_gnt !== 1'b1 || o_ls_rvalid !== 1'b1 ||
        o_mc_addr !== 13'h0200 || o_mc_rd_mode !== 2'd1) begin
      bad++;
      $display("FAIL b2b_if gnt=%b lsrv=%b addr=%h rd=%0d want 1 1 0200 1",
               o_if_gnt, o_ls_rvalid, o_mc_addr, o_mc_rd_mode);
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if (o_if_rvalid !== 1'b1 || o_ls_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_resp ifrv=%b lsrv=%b want 1 0",
               o_if_rvalid, o_ls_rvalid);
    end
  endtask

  task automatic test_store8();
    step();
    i_ls_req = 1'b1;
    i_ls_addr = 13'h0003;
    i_ls_wdata = 32'h0000_00AB;
    i_ls_wr_mode = 2'd3;
    @(negedge clk);
    total++;
    if (o_ls_gnt !== 1'b1 || o_mc_wr_mode !== 2'd3 ||
        o_mc_rd_mode !== 2'd0 || o_mc_data !== 32'h0000_00AB ||
        o_mc_addr !== 13'h0003) begin
      bad++;
      $display("FAIL st8_issue gnt=%b wr=%0d rd=%0d data=%h addr=%h want 1 3 0 000000ab 0003",
               o_ls_gnt, o_mc_wr_mode, o_mc_rd_mode, o_mc_data, o_mc_addr);
    end
    step();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (o_ls_rvalid !== 1'b0 || o_if_rvalid !== 1'b0 || o_err !== 1'b0) begin
        bad++;
        $display("FAIL st8_norv%0d lsrv=%b ifrv=%b err=%b want 0 0 0",
                 c, o_ls_rvalid, o_if_rvalid, o_err);
      end
      step();
    end
  endtask

  task automatic test_err();
    i_ls_req = 1'b1;
    i_ls_addr = 13'h0050;
    i_ls_wdata = 32'h0000_1234;
    i_ls_rd_mode = 2'd1;
    i_ls_wr_mode = 2'd1;
    @(negedge clk);
    total++;
    if (o_ls_gnt !== 1'b1 || o_mc_rd_mode !== 2'd0 ||
        o_mc_wr_mode !== 2'd1 || o_err !== 1'b0) begin
      bad++;
      $display("FAIL err_issue gnt=%b rd=%0d wr=%0d err=%b want 1 0 1 0",
               o_ls_gnt, o_mc_rd_mode, o_mc_wr_mode, o_err);
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if (o_err !== 1'b1 || o_ls_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL err_set err=%b lsrv=%b want 1 0", o_err, o_ls_rvalid);
    end
    step();
    i_if_req = 1'b1;
    i_if_addr = 13'h0300;
    i_if_mode = 2'd3;
    @(negedge clk);
    total++;
    if (o_if_gnt !== 1'b1 || o_mc_rd_mode !== 2'd0) begin
      bad++;
      $display("FAIL if_bad_mode gnt=%b rd=%0d want 1 0",
               o_if_gnt, o_mc_rd_mode);
    end
    step();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (o_err !== 1'b1 || o_if_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL err_sticky%0d err=%b ifrv=%b want 1 0",
                 c, o_err, o_if_rvalid);
      end
      step();
    end
  endtask

  task automatic test_reset_hold32();
    i_ls_req = 1'b1;
    i_ls_addr = 13'h0060;
    i_ls_rd_mode = 2'd2;
    @(negedge clk);
    total++;
    if (o_ls_gnt !== 1'b1 || o_mc_rd_mode !== 2'd2) begin
      bad++;
      $display("FAIL rh_issue gnt=%b rd=%0d want 1 2", o_ls_gnt, o_mc_rd_mode);
    end
    step();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({o_ls_gnt, o_ls_rvalid, o_if_rvalid, o_err,
         o_mc_rd_mode, o_mc_wr_mode} !== 8'd0 ||
        o_mc_addr !== 13'd0 || o_rdata !== 32'd0) begin
      bad++;
      $display("FAIL rh_inrst gnt=%b lsrv=%b err=%b rd=%0d addr=%h rdata=%h want 0",
               o_ls_gnt, o_ls_rvalid, o_err, o_mc_rd_mode, o_mc_addr, o_rdata);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (o_ls_rvalid !== 1'b0 || o_err !== 1'b0 ||
          o_mc_addr !== 13'd0) begin
        bad++;
        $display("FAIL rh_after%0d lsrv=%b err=%b addr=%h want 0 0 0",
                 c, o_ls_rvalid, o_err, o_mc_addr);
      end
      step();
    end
    i_ls_req = 1'b1;
    i_ls_addr = 13'h0070;
    i_ls_rd_mode = 2'd1;
    @(negedge clk);
    total++;
    if (o_ls_gnt !== 1'b1 || o_mc_rd_mode !== 2'd1) begin
      bad++;
      $display("FAIL rh_idle gnt=%b rd=%0d want 1 1", o_ls_gnt, o_mc_rd_mode);
    end
    step();
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_ls_load16();
    test_if32();
    test_streak();
    test_back_to_back();
    test_store8();
    test_err();
    test_reset_hold32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
